nios_system_tick_monitor: RTL
=============================

// Module: nios_system_tick_monitor
// PURPOSE
//  Downstream consumer of the system interval timer's irq line. Measures ISR service latency
//  (cycles tick_irq stays high), counts serviced ticks, tracks worst-case latency, and flags an
//  overrun (optional irq / reset request) when latency exceeds a programmable limit.
//  Avalon-MM 16-bit slave on the Nios data master; 8-word register map.
// PARAMETERS
//  LIMIT_RESET         50000  reset value of the 32-bit latency limit, in clk cycles
//  RESET_PULSE_CYCLES  16     width of the reset_req pulse, in clk cycles (>=1)
// PORTS
//  clk        in   1   system clock; the only clock
//  reset_n    in   1   asynchronous, active-low reset
//  address    in   3   register word address
//  chipselect in   1   slave select
//  write_n    in   1   active-low write strobe
//  writedata  in   16  write data
//  readdata   out  16  registered read data
//  tick_irq   in   1   timer irq, synchronous to clk
//  irq        out  1   overrun interrupt
//  reset_req  out  1   system reset request pulse
// BEHAVIOUR
//  Reset: readdata=0, irq=0, reset_req=0, FSM=IDLE, control=0, limit=LIMIT_RESET,
//   tick_count=0, max_lat=0, lat=0, snapshots=0, overrun_flag=0, tick_irq_d=0.
//  Write decode: wr = chipselect & ~write_n. Read: readdata <= mux(address) every cycle (1-cycle latency).
//  Map: 0 STATUS  rd {13'b0, rst_req_active, pending, overrun_flag}; any write clears overrun_flag.
//       1 CONTROL rd/wr [0]=irq_en [1]=mon_en [2]=rst_en; bits [15:3] read 0.
//       2/3 LIMIT_L/H rd/wr; each half takes effect the cycle after its write; a mixed-half
//         compare during a two-write update is accepted.
//       4/5 COUNT_L/H rd snapshot of tick_count; write to either snapshots tick_count AND max_lat.
//       6/7 MAXLAT_L/H rd snapshot of max_lat; write to either clears live max_lat to 0.
//  rise = tick_irq & ~tick_irq_d.
//  FSM IDLE:    rise & mon_en -> PENDING, lat<=0.
//       PENDING: lat increments each cycle, saturates at 32'hFFFF_FFFF.
//                ~tick_irq -> IDLE: tick_count+=1 (wraps 2^32), max_lat<=max(max_lat,lat).
//                else lat>=limit -> OVERRUN: overrun_flag<=1; reset_req pulse starts if rst_en.
//       OVERRUN: lat keeps counting; ~tick_irq -> IDLE with same count/max update as PENDING.
//   Falling-edge check has priority over limit check in the same cycle.
//   mon_en cleared in PENDING/OVERRUN -> IDLE next cycle; lat discarded, no count/max update.
//   limit=0: OVERRUN entered one cycle after PENDING entry if tick_irq still high.
//   tick_irq high while entering/held in IDLE with no rise (e.g. mon_en set mid-pulse): ignored.
//  pending = (FSM != IDLE). irq = overrun_flag & irq_en (combinational from regs).
//  reset_req: high exactly RESET_PULSE_CYCLES cycles from the cycle after OVERRUN entry; not
//   retriggerable; rst_req_active mirrors it. Clearing rst_en mid-pulse does not truncate it.
//  Simultaneous events: overrun set + STATUS write -> flag set (set wins).
//   Snapshot write + tick_count increment -> snapshot holds pre-increment value.
//   MAXLAT write + max_lat update -> cleared (clear wins).
// STRUCTURE
//  Shared package: register address constants (0..7), CONTROL bit indices, FSM state encoding
//   (IDLE/PENDING/OVERRUN), LAT_MAX = 32'hFFFF_FFFF.
//  One sub-module: nios_system_tick_latency_tracker - saturating lat counter plus max_lat register
//   with clear; top holds bus decode, FSM, tick_count, snapshots, reset pulse timer.
// TESTING
//  1 mon_en=1, limit=100; tick_irq high 10 cycles -> tick_count=1, max_lat=9 via snapshot, irq=0.
//  2 limit=5, irq_en=1, rst_en=1; tick_irq high 20 cycles -> overrun_flag=1 after 6 cycles
//    in PENDING, irq=1, reset_req high exactly 16 cycles; STATUS write -> irq=0.
//  3 Latencies 30, 80, 50 -> max_lat=80; MAXLAT write -> next snapshot max_lat=0, count=3.
//  4 mon_en cleared 3 cycles into PENDING -> FSM IDLE, tick_count unchanged, max_lat unchanged.
//  5 tick_count preloaded near 32'hFFFF_FFFF via 2^32-1 short ticks (force) -> one more tick wraps
//    to 0; snapshot taken on the increment cycle reads 32'hFFFF_FFFF.
//  6 Assert reset_n mid-OVERRUN with reset_req high -> all outputs 0 immediately, limit=50000.

Source files
------------

// File: rtl/nios_system_tick_monitor_pkg.sv
// Shared constants for the system tick monitor: register map, CONTROL bits,
// FSM encoding and the latency saturation value.
package nios_system_tick_monitor_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_LIMIT_L = 3'd2;
  localparam logic [2:0] ADDR_LIMIT_H = 3'd3;
  localparam logic [2:0] ADDR_COUNT_L = 3'd4;
  localparam logic [2:0] ADDR_COUNT_H = 3'd5;
  localparam logic [2:0] ADDR_MAXLAT_L = 3'd6;
  localparam logic [2:0] ADDR_MAXLAT_H = 3'd7;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_MON_EN = 1;
  localparam int CTRL_RST_EN = 2;

  localparam logic [31:0] LAT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_OVERRUN = 2'd2
  } state_e;

endpackage

// File: rtl/nios_system_tick_latency_tracker.sv
// Saturating service-latency counter plus worst-case latency register.
// The clear input on max_lat overrides a simultaneous update.
module nios_system_tick_latency_tracker
  import nios_system_tick_monitor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lat_clr_i,
  input  logic        lat_inc_i,
  input  logic        max_upd_i,
  input  logic        max_clr_i,
  output logic [31:0] lat_o,
  output logic [31:0] max_lat_o
);

  logic [31:0] lat_q, lat_d;
  logic [31:0] max_lat_q, max_lat_d;

  // Next-state for the latency counter and the worst-case register.
  always_comb begin
    lat_d     = lat_q;
    max_lat_d = max_lat_q;
    if (lat_clr_i) begin
      lat_d = 32'd0;
    end else if (lat_inc_i && (lat_q != LAT_MAX)) begin
      lat_d = lat_q + 32'd1;
    end
    if (max_clr_i) begin
      max_lat_d = 32'd0;
    end else if (max_upd_i && (lat_q > max_lat_q)) begin
      max_lat_d = lat_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q     <= 32'd0;
      max_lat_q <= 32'd0;
    end else begin
      lat_q     <= lat_d;
      max_lat_q <= max_lat_d;
    end
  end

  assign lat_o     = lat_q;
  assign max_lat_o = max_lat_q;

endmodule

// File: rtl/nios_system_tick_monitor.sv
// System tick monitor: measures how long the timer irq stays high (ISR
// service latency), counts serviced ticks, tracks the worst case and flags
// overruns past a programmable limit. 16-bit Avalon-MM slave, 8 words.
module nios_system_tick_monitor
  import nios_system_tick_monitor_pkg::*;
#(
  parameter logic [31:0] LIMIT_RESET        = 32'd50000,
  parameter int unsigned RESET_PULSE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        tick_irq,
  output logic        irq,
  output logic        reset_req
);

  localparam int RC_W = $clog2(RESET_PULSE_CYCLES + 1);

  state_e      state_q, state_d;
  logic [2:0]  control_q, control_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [31:0] snap_cnt_q, snap_cnt_d;
  logic [31:0] snap_max_q, snap_max_d;
  logic        overrun_flag_q, overrun_flag_d;
  logic        tick_irq_d_q;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [15:0] readdata_q, readdata_d;

  logic        wr, wr_status, wr_control, wr_lim_l, wr_lim_h, wr_count, wr_maxlat;
  logic        rise, mon_en;
  logic        lat_clr, lat_inc, tick_done, ovr_set;
  logic        rst_active;
  logic [31:0] lat, max_lat;

  assign wr         = chipselect & ~write_n;
  assign wr_status  = wr && (address == ADDR_STATUS);
  assign wr_control = wr && (address == ADDR_CONTROL);
  assign wr_lim_l   = wr && (address == ADDR_LIMIT_L);
  assign wr_lim_h   = wr && (address == ADDR_LIMIT_H);
  assign wr_count   = wr && ((address == ADDR_COUNT_L) || (address == ADDR_COUNT_H));
  assign wr_maxlat  = wr && ((address == ADDR_MAXLAT_L) || (address == ADDR_MAXLAT_H));

  assign rise       = tick_irq & ~tick_irq_d_q;
  assign mon_en     = control_q[CTRL_MON_EN];
  assign rst_active = (rst_cnt_q != '0);

  nios_system_tick_latency_tracker u_tracker (
    .clk       (clk),
    .rst_n     (reset_n),
    .lat_clr_i (lat_clr),
    .lat_inc_i (lat_inc),
    .max_upd_i (tick_done),
    .max_clr_i (wr_maxlat),
    .lat_o     (lat),
    .max_lat_o (max_lat)
  );

  // FSM next state: disabling the monitor wins, then the irq falling edge,
  // then the limit check.
  always_comb begin
    state_d   = state_q;
    lat_clr   = 1'b0;
    lat_inc   = 1'b0;
    tick_done = 1'b0;
    ovr_set   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise && mon_en) begin
          state_d = ST_PENDING;
          lat_clr = 1'b1;
        end
      end
      ST_PENDING: begin
        lat_inc = 1'b1;
        if (!mon_en) begin
          state_d = ST_IDLE;
        end else if (!tick_irq) begin
          state_d   = ST_IDLE;
          tick_done = 1'b1;
        end else if (lat >= limit_q) begin
          state_d = ST_OVERRUN;
          ovr_set = 1'b1;
        end
      end
      ST_OVERRUN: begin
        lat_inc = 1'b1;
        if (!mon_en) begin
          state_d = ST_IDLE;
        end else if (!tick_irq) begin
          state_d   = ST_IDLE;
          tick_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register-file, counter, snapshot and reset-pulse next state.
  always_comb begin
    control_d      = control_q;
    limit_d        = limit_q;
    tick_count_d   = tick_count_q;
    snap_cnt_d     = snap_cnt_q;
    snap_max_d     = snap_max_q;
    overrun_flag_d = overrun_flag_q;
    rst_cnt_d      = rst_cnt_q;

    if (wr_control) control_d = writedata[2:0];
    if (wr_lim_l)   limit_d[15:0]  = writedata;
    if (wr_lim_h)   limit_d[31:16] = writedata;
    if (tick_done)  tick_count_d = tick_count_q + 32'd1;
    // Snapshots capture the live values before this cycle's update.
    if (wr_count) begin
      snap_cnt_d = tick_count_q;
      snap_max_d = max_lat;
    end
    // A new overrun outranks a software clear in the same cycle.
    if (ovr_set)        overrun_flag_d = 1'b1;
    else if (wr_status) overrun_flag_d = 1'b0;
    // Pulse timer is not retriggerable and ignores rst_en once running.
    if (rst_active)
      rst_cnt_d = rst_cnt_q - RC_W'(1);
    else if (ovr_set && control_q[CTRL_RST_EN])
      rst_cnt_d = RC_W'(RESET_PULSE_CYCLES);
  end

  // Read mux, registered every cycle.
  always_comb begin
    readdata_d = 16'd0;
    unique case (address)
      ADDR_STATUS:   readdata_d = {13'd0, rst_active, (state_q != ST_IDLE), overrun_flag_q};
      ADDR_CONTROL:  readdata_d = {13'd0, control_q};
      ADDR_LIMIT_L:  readdata_d = limit_q[15:0];
      ADDR_LIMIT_H:  readdata_d = limit_q[31:16];
      ADDR_COUNT_L:  readdata_d = snap_cnt_q[15:0];
      ADDR_COUNT_H:  readdata_d = snap_cnt_q[31:16];
      ADDR_MAXLAT_L: readdata_d = snap_max_q[15:0];
      ADDR_MAXLAT_H: readdata_d = snap_max_q[31:16];
      default:       readdata_d = 16'd0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      control_q      <= 3'd0;
      limit_q        <= LIMIT_RESET;
      snap_cnt_q     <= 32'd0;
      snap_max_q     <= 32'd0;
      overrun_flag_q <= 1'b0;
      tick_irq_d_q   <= 1'b0;
      rst_cnt_q      <= '0;
      readdata_q     <= 16'd0;
    end else begin
      state_q        <= state_d;
      control_q      <= control_d;
      limit_q        <= limit_d;
      snap_cnt_q     <= snap_cnt_d;
      snap_max_q     <= snap_max_d;
      overrun_flag_q <= overrun_flag_d;
      tick_irq_d_q   <= tick_irq;
      rst_cnt_q      <= rst_cnt_d;
      readdata_q     <= readdata_d;
    end
  end

  // Tick counter only loads on a serviced tick so its value is held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       tick_count_q <= 32'd0;
    else if (tick_done) tick_count_q <= tick_count_d;
  end

  assign readdata  = readdata_q;
  assign irq       = overrun_flag_q & control_q[CTRL_IRQ_EN];
  assign reset_req = rst_active;

endmodule
